lfsr_run_ctrl: RTL

- Sequencer for one WIDTH-bit right-shifting Galois-free LFSR.
- Accepts a start command with taps, seed and an optional step budget, then clocks the LFSR one step per cycle.
- Stops when the state returns to the seed (period found) or when the budget is exhausted, and reports the final value and step count.
- Sits between the lab control logic and the LFSR datapath; used for period measurement and fixed-length sequence generation.

---
 rtl/lfsr_run_ctrl_pkg.sv | 32 +++
 rtl/lfsr_run_ctrl_if.sv | 28 ++
 rtl/lfsr_run_ctrl_core.sv | 42 ++++
 rtl/lfsr_run_ctrl.sv | 113 +++++++++++
 4 files changed

// File: rtl/lfsr_run_ctrl_pkg.sv
// lfsr_pkg: shared definitions for the LFSR sequencer family.
//   - FSM state encoding for lfsr_run_ctrl.
//   - lfsr_next(): the common right-shifting LFSR step. The 3/4/8-bit LFSRs
//     and lfsr_run_ctrl call it so that they all step the same way.
//     The caller passes the width (up to 16) and zero-extended operands.
package lfsr_pkg;

  localparam int unsigned LFSR_MAX_W = 16;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // fb   = v[0] ^ XOR_{i=0..w-2} (taps[i] & v[w-1-i])
  // next = {fb, v[w-1:1]}
  // The operand is aligned to bit 15 and then bit-reversed, so rev[i] == v[w-1-i].
  // Masking the taps to bits 0..w-2 turns the whole sum into one parity reduction.
  function automatic logic [15:0] lfsr_next(input logic [15:0] taps,
                                            input logic [15:0] value,
                                            input int          width);
    logic [15:0] aligned;
    logic [15:0] rev;
    logic [15:0] tap_mask;
    logic        fb;
    aligned  = value << (LFSR_MAX_W - width);
    rev      = {<<{aligned}};
    tap_mask = (16'h0001 << (width - 1)) - 16'h0001;
    fb       = value[0] ^ (^(taps & tap_mask & rev));
    return (value >> 1) | (16'(fb) << (width - 1));
  endfunction

endpackage

// File: rtl/lfsr_run_ctrl_if.sv
// lfsr_run_ctrl_if: command/result bundle for lfsr_run_ctrl.
//   master: lab control side. It drives start and cfg_* and reads the results.
//   slave : the sequencer. It reads the command and drives busy, done,
//           value, steps_taken, period_found and budget_hit.
interface lfsr_run_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] cfg_taps;
  logic [WIDTH-1:0] cfg_seed;
  logic [WIDTH-1:0] cfg_steps;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] value;
  logic [WIDTH-1:0] steps_taken;
  logic             period_found;
  logic             budget_hit;

  modport master (
    output start, cfg_taps, cfg_seed, cfg_steps,
    input  busy, done, value, steps_taken, period_found, budget_hit
  );

  modport slave (
    input  start, cfg_taps, cfg_seed, cfg_steps,
    output busy, done, value, steps_taken, period_found, budget_hit
  );
endinterface

// File: rtl/lfsr_run_ctrl_core.sv
// lfsr_core_sync: the LFSR state register.
//   clock      rising-edge clock
//   reset      synchronous, active-low; clears the state to 0
//   load       loads load_value (has priority over step)
//   load_value value to load
//   step       advances the state by one lfsr_next() step
//   taps       tap mask (bit WIDTH-1 ignored)
//   value      current state (registered)
module lfsr_core_sync
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             step,
  input  logic [WIDTH-1:0] taps,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] value_d, value_q;

  always_comb begin
    value_d = value_q;
    if (load)
      value_d = load_value;
    else if (step)
      value_d = WIDTH'(lfsr_next(16'(taps), 16'(value_q), WIDTH));
  end

  always_ff @(posedge clock) begin
    if (!reset)
      value_q <= '0;
    else
      value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/lfsr_run_ctrl.sv
// lfsr_run_ctrl: runs one LFSR until its state returns to the seed or until
// an optional step budget runs out. It then reports the final state, the
// step count and the reason the run ended.
//   clock  rising-edge clock
//   reset  synchronous, active-low
//   bus    lfsr_run_ctrl_if.slave:
//            start, cfg_taps, cfg_seed, cfg_steps    (command, captured on start)
//            busy, done, value, steps_taken,
//            period_found, budget_hit                (registered results)
module lfsr_run_ctrl
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  lfsr_run_ctrl_if.slave       bus
);

  logic [1:0]       state_d, state_q;
  logic [WIDTH-1:0] steps_d, steps_q;
  logic [WIDTH-1:0] taps_d, taps_q;
  logic [WIDTH-1:0] seed_d, seed_q;
  logic [WIDTH-1:0] budget_d, budget_q;
  logic             pf_d, pf_q;
  logic             bh_d, bh_q;

  logic             core_load;
  logic             core_step;
  logic [WIDTH-1:0] value;
  logic [WIDTH-1:0] value_nxt;
  logic [WIDTH-1:0] steps_inc;

  lfsr_core_sync #(.WIDTH(WIDTH)) u_core (
    .clock      (clock),
    .reset      (reset),
    .load       (core_load),
    .load_value (bus.cfg_seed),
    .step       (core_step),
    .taps       (taps_q),
    .value      (value)
  );

  // The termination check looks at the state that this step produces. The
  // comparator therefore evaluates the same step that the core is about to take.
  assign value_nxt = WIDTH'(lfsr_next(16'(taps_q), 16'(value), WIDTH));
  assign steps_inc = steps_q + WIDTH'(1);

  always_comb begin
    state_d   = state_q;
    steps_d   = steps_q;
    taps_d    = taps_q;
    seed_d    = seed_q;
    budget_d  = budget_q;
    pf_d      = pf_q;
    bh_d      = bh_q;
    core_load = 1'b0;
    core_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          taps_d    = bus.cfg_taps;
          seed_d    = bus.cfg_seed;
          budget_d  = bus.cfg_steps;
          steps_d   = '0;
          pf_d      = 1'b0;
          bh_d      = 1'b0;
          core_load = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        core_step = 1'b1;
        steps_d   = steps_inc;
        pf_d      = (value_nxt == seed_q);
        // A budget of 0 means there is no budget.
        bh_d      = (budget_q != '0) && (steps_inc == budget_q);
        if (pf_d || bh_d)
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      steps_q  <= '0;
      taps_q   <= '0;
      seed_q   <= '0;
      budget_q <= '0;
      pf_q     <= 1'b0;
      bh_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      steps_q  <= steps_d;
      taps_q   <= taps_d;
      seed_q   <= seed_d;
      budget_q <= budget_d;
      pf_q     <= pf_d;
      bh_q     <= bh_d;
    end
  end

  assign bus.busy         = (state_q == RUN);
  assign bus.done         = (state_q == DONE);
  assign bus.value        = value;
  assign bus.steps_taken  = steps_q;
  assign bus.period_found = pf_q;
  assign bus.budget_hit   = bh_q;

endmodule
